// File: rtl/alu_pkg.sv
// Shared constants and types for the handshaked ALU responder.
// The func encoding matches the existing 8-bit combinational ALU so command
// sequencers can target either unit without translation.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [2:0] FUNC_ADD = 3'd0;
  localparam logic [2:0] FUNC_SUB = 3'd1;
  localparam logic [2:0] FUNC_AND = 3'd2;
  localparam logic [2:0] FUNC_OR  = 3'd3;
  localparam logic [2:0] FUNC_XOR = 3'd4;
  localparam logic [2:0] FUNC_NOT = 3'd5;
  localparam logic [2:0] FUNC_SHL = 3'd6;
  localparam logic [2:0] FUNC_SHR = 3'd7;

  // IDLE accepts, SHIFT iterates one bit per cycle, RESP holds the result
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } alu_state_e;

  // Shifts are the only operations that leave through the iterative path
  function automatic logic isShiftFunc(input logic [2:0] func);
    return (func == FUNC_SHL) || (func == FUNC_SHR);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle part of the ALU: add, subtract and the bitwise operations.
// Pure combinational logic; the responder registers its outputs at accept.
// Shift codes produce zero here because the responder never uses this result
// for them.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       func_i,
  output logic [WIDTH-1:0] result_o,
  output logic             flag_o
);

  logic [WIDTH:0] sumWide;

  // Extra top bit of the widened sum is the carry out of an ADD
  assign sumWide = {1'b0, a_i} + {1'b0, b_i};

  // Select the result and flag; flag is only meaningful for ADD and SUB
  always_comb begin
    result_o = '0;
    flag_o   = 1'b0;
    case (func_i)
      FUNC_ADD: begin
        result_o = sumWide[WIDTH-1:0];
        flag_o   = sumWide[WIDTH];
      end
      FUNC_SUB: begin
        result_o = a_i - b_i;
        flag_o   = (a_i < b_i);
      end
      FUNC_AND: result_o = a_i & b_i;
      FUNC_OR:  result_o = a_i | b_i;
      FUNC_XOR: result_o = a_i ^ b_i;
      FUNC_NOT: result_o = ~a_i;
      default: begin
        result_o = '0;
        flag_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_responder.sv
// Handshaked, registered ALU execution unit.
// One request is taken over valid/ready, computed (immediately for func 0-5,
// one bit per cycle for shifts) and held on the response channel until the
// consumer takes it. The unit only accepts in IDLE, so a handoff and a new
// accept never share a cycle.
module alu_responder
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_func,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_flag
);

  alu_state_e       state_q;
  logic [WIDTH-1:0] acc_q;
  logic             flag_q;
  logic [SHW-1:0]   shiftCnt_q;
  logic             shiftLeft_q;

  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [2:0]       opFunc;
  logic [SHW-1:0]   shiftAmt;
  logic [WIDTH-1:0] coreResult;
  logic             coreFlag;
  logic [WIDTH-1:0] acc_d;
  logic             flag_d;

  // Request fields are forced to zero while no request is present so that
  // undriven inputs from an idle sender never reach the datapath.
  assign opA      = req_valid ? req_a    : '0;
  assign opB      = req_valid ? req_b    : '0;
  assign opFunc   = req_valid ? req_func : '0;
  assign shiftAmt = opB[SHW-1:0];

  alu_comb_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a_i     (opA),
    .b_i     (opB),
    .func_i  (opFunc),
    .result_o(coreResult),
    .flag_o  (coreFlag)
  );

  // One-bit shift step of the accumulator; the bit that falls off becomes the flag
  always_comb begin
    acc_d  = acc_q;
    flag_d = flag_q;
    if (shiftLeft_q) begin
      acc_d  = {acc_q[WIDTH-2:0], 1'b0};
      flag_d = acc_q[WIDTH-1];
    end else begin
      acc_d  = {1'b0, acc_q[WIDTH-1:1]};
      flag_d = acc_q[0];
    end
  end

  // Control FSM and result registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      flag_q      <= 1'b0;
      shiftCnt_q  <= '0;
      shiftLeft_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (isShiftFunc(opFunc)) begin
              acc_q       <= opA;
              flag_q      <= 1'b0;
              shiftLeft_q <= (opFunc == FUNC_SHL);
              shiftCnt_q  <= shiftAmt;
              if (shiftAmt == '0) begin
                state_q <= RESP;
              end else begin
                state_q <= SHIFT;
              end
            end else begin
              acc_q   <= coreResult;
              flag_q  <= coreFlag;
              state_q <= RESP;
            end
          end
        end
        SHIFT: begin
          acc_q      <= acc_d;
          flag_q     <= flag_d;
          shiftCnt_q <= shiftCnt_q - SHW'(1);
          if (shiftCnt_q == SHW'(1)) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_result = acc_q;
  assign rsp_flag   = flag_q;

endmodule

// File: tb/tb_alu_responder.sv
// Self-checking bench for alu_responder: directed cases, backpressure,
// reset during a shift and a randomized sweep against a behavioural model.
module tb_alu_responder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [2:0]   req_func;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_flag;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_responder #(.WIDTH(W), .SHW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_func  (req_func),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_flag  (rsp_flag)
  );

  // Reference model: {flag, result} from plain integer arithmetic
  function automatic logic [8:0] refAlu(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] f);
    int ai = a;
    int bi = b;
    int n  = b % 8;
    int r  = 0;
    logic fl = 1'b0;
    case (f)
      3'd0: begin r = ai + bi; fl = (r > 255); r = r % 256; end
      3'd1: begin r = (ai - bi + 256) % 256; fl = (ai < bi); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = 255 - ai;
      3'd6: begin
        r  = (ai * (2 ** n)) % 256;
        fl = (n == 0) ? 1'b0 : (((ai * (2 ** n)) / 256) % 2 == 1);
      end
      default: begin
        r  = ai / (2 ** n);
        fl = (n == 0) ? 1'b0 : ((ai / (2 ** (n - 1))) % 2 == 1);
      end
    endcase
    return {fl, r[7:0]};
  endfunction

  function automatic int refLatency(input logic [7:0] b, input logic [2:0] f);
    if (f >= 3'd6 && (b % 8) != 0) return 1 + (b % 8);
    return 1;
  endfunction

  // Drive one request, wait for the response, hold it for 'stall' cycles, then take it
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f,
                               input int stall, input bit noisy,
                               output logic [7:0] res, output logic flg, output int lat,
                               output bit stable, output bit dropped);
    int w = 0;
    res = '0; flg = 1'b0; lat = 0; stable = 1'b1; dropped = 1'b0;
    @(negedge clk);
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    if (!req_ready) return;
    req_valid = 1'b1; req_a = a; req_b = b; req_func = f; rsp_ready = 1'b0;
    @(negedge clk);
    lat = 1;
    req_valid = 1'b0; req_a = W'($urandom); req_b = W'($urandom); req_func = 3'($urandom);
    while (!rsp_valid && lat < 20) begin
      if (noisy) rsp_ready = 1'($urandom % 2);
      @(negedge clk);
      lat++;
    end
    rsp_ready = 1'b0;
    if (!rsp_valid) begin lat = -1; return; end
    res = rsp_result;
    flg = rsp_flag;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_result !== res || rsp_flag !== flg || req_ready !== 1'b0)
        stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    dropped = (rsp_valid === 1'b0) && (req_ready === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_func = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%0b exp=0", rsp_valid); end
    checks++; if (rsp_result !== 8'd0) begin failures++; $display("[TB] FAIL reset_result got=%0d exp=0", rsp_result); end
    checks++; if (rsp_flag !== 1'b0) begin failures++; $display("[TB] FAIL reset_flag got=%0b exp=0", rsp_flag); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%0b exp=1", req_ready); end
  endtask

  task automatic test_directed();
    logic [7:0] ta [7] = '{8'd75, 8'd200, 8'd61, 8'd75, 8'h81, 8'h81, 8'h5A};
    logic [7:0] tb [7] = '{8'd61, 8'd100, 8'd75, 8'd61, 8'd3, 8'd1, 8'd0};
    logic [2:0] tf [7] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd6, 3'd7, 3'd6};
    logic [7:0] er [7] = '{8'd136, 8'd44, 8'd242, 8'd14, 8'h08, 8'h40, 8'h5A};
    logic       ef [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int         el [7] = '{1, 1, 1, 1, 4, 2, 1};
    logic [7:0] res; logic flg; int lat; bit stable; bit dropped;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(ta[i], tb[i], tf[i], 0, 1'b0, res, flg, lat, stable, dropped);
      checks++; if (res !== er[i]) begin failures++; $display("[TB] FAIL directed%0d_result got=%0d exp=%0d", i, res, er[i]); end
      checks++; if (flg !== ef[i]) begin failures++; $display("[TB] FAIL directed%0d_flag got=%0b exp=%0b", i, flg, ef[i]); end
      checks++; if (lat != el[i]) begin failures++; $display("[TB] FAIL directed%0d_latency got=%0d exp=%0d", i, lat, el[i]); end
    end
  endtask

  task automatic test_backpressure();
    int w = 0;
    bit stable = 1'b1;
    @(negedge clk);
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    req_valid = 1'b1; req_a = 8'd200; req_b = 8'd100; req_func = 3'd0; rsp_ready = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 8'd44 || rsp_flag !== 1'b1) begin
      failures++; $display("[TB] FAIL bp_first got=%0b/%0d/%0b exp=1/44/1", rsp_valid, rsp_result, rsp_flag);
    end
    req_a = 8'd61; req_b = 8'd75; req_func = 3'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_result !== 8'd44 || rsp_flag !== 1'b1 || req_ready !== 1'b0) stable = 1'b0;
    end
    checks++; if (!stable) begin failures++; $display("[TB] FAIL bp_stable got=unstable exp=stable"); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL bp_handoff got=valid%0b/ready%0b exp=valid0/ready1", rsp_valid, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 8'd242 || rsp_flag !== 1'b1) begin
      failures++; $display("[TB] FAIL bp_second got=%0b/%0d/%0b exp=1/242/1", rsp_valid, rsp_result, rsp_flag);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    int w = 0;
    int stale = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    req_valid = 1'b1; req_a = 8'hFF; req_b = 8'd7; req_func = 3'd6;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_valid got=%0b exp=0", rsp_valid); end
    checks++; if (rsp_result !== 8'd0) begin failures++; $display("[TB] FAIL midrst_result got=%0d exp=0", rsp_result); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrst_ready got=%0b exp=1", req_ready); end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin failures++; $display("[TB] FAIL midrst_stale got=%0d exp=0", stale); end
  endtask

  task automatic test_sweep();
    logic [7:0] res; logic flg; int lat; bit stable; bit dropped;
    logic [7:0] a; logic [7:0] b; logic [2:0] f; logic [8:0] exp;
    int issued = 0;
    int received = 0;
    for (int i = 0; i < 48; i++) begin
      if (i < 8) begin a = 8'd75; b = 8'd61; f = 3'(i); end
      else begin a = 8'($urandom); b = 8'($urandom); f = 3'($urandom); end
      exp = refAlu(a, b, f);
      issued++;
      applyStimulus(a, b, f, int'($urandom_range(0, 3)), 1'b1, res, flg, lat, stable, dropped);
      if (lat > 0 && dropped) received++;
      checks++; if (res !== exp[7:0]) begin failures++; $display("[TB] FAIL sweep%0d_result f=%0d a=%0d b=%0d got=%0d exp=%0d", i, f, a, b, res, exp[7:0]); end
      checks++; if (flg !== exp[8]) begin failures++; $display("[TB] FAIL sweep%0d_flag f=%0d a=%0d b=%0d got=%0b exp=%0b", i, f, a, b, flg, exp[8]); end
      checks++; if (lat != refLatency(b, f)) begin failures++; $display("[TB] FAIL sweep%0d_latency got=%0d exp=%0d", i, lat, refLatency(b, f)); end
      checks++; if (!stable) begin failures++; $display("[TB] FAIL sweep%0d_stable got=unstable exp=stable", i); end
    end
    checks++; if (received != issued) begin failures++; $display("[TB] FAIL sweep_count got=%0d exp=%0d", received, issued); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_shift();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so a stuck handshake can never hang the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
